// File: rtl/piezo_fanfare_pkg.sv
// Shared types, note table and duration step for the piezo fanfare player.
// FAST_SIM_EN selects a 16x duration step so the tune plays 16x faster in simulation.
package piezo_pkg;

   typedef enum logic {IDLE, PLAY} fanfare_state_t;
   typedef logic [2:0] note_idx_t;

   localparam int NUM_NOTES = 6;
   localparam int PER_W     = 15;
   localparam int DUR_W     = 26;

   // G6 C7 E7 G7 E7 G7; periods below are for the 50 MHz reference clock
   localparam int NOTE_FREQ_HZ [NUM_NOTES] = '{1568, 2093, 2637, 3136, 2637, 3136};

   localparam logic [PER_W-1:0] NOTE_PERIOD [NUM_NOTES] =
      '{15'd31888, 15'd23889, 15'd18961, 15'd15944, 15'd18961, 15'd15944};

   localparam logic [DUR_W:0] NOTE_DUR [NUM_NOTES] =
      '{27'd8388608, 27'd8388608, 27'd8388608, 27'd12582912, 27'd4194304, 27'd33554432};

`ifdef FAST_SIM_EN
   localparam int STEP = 16;
`else
   localparam int STEP = 1;
`endif

   // Nearest-integer clock count for one cycle of a note
   function automatic logic [PER_W-1:0] note_period(input int clk_hz, input int freq_hz);
      return PER_W'((clk_hz + freq_hz / 2) / freq_hz);
   endfunction

endpackage

// File: rtl/piezo_fanfare_tone_gen.sv
// Square-wave generator: free-running period counter, high for the first half-period.
module tone_gen
   import piezo_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [PER_W-1:0] period,
   input  logic             clr,
   output logic             sq
);

   logic [PER_W-1:0] per_cnt_q, per_cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) per_cnt_q <= '0;
      else     per_cnt_q <= per_cnt_d;
   end

   always_comb begin
      per_cnt_d = per_cnt_q + 1'b1;
      if (clr || per_cnt_q >= period - 1'b1) per_cnt_d = '0;
   end

   assign sq = (per_cnt_q < (period >> 1));

endmodule

// File: rtl/piezo_fanfare.sv
// Fanfare player: walks the six-note table on go, driving a differential square wave.
// Build with FAST_SIM_EN for the accelerated duration step (see piezo_pkg).
module piezo_fanfare
   import piezo_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int STEP_SIZE   = STEP
) (
   input  logic clk,
   input  logic rst,
   input  logic go,
   output logic piezo,
   output logic piezo_n,
   output logic busy,
   output logic done
);

   localparam note_idx_t LAST_NOTE = note_idx_t'(NUM_NOTES - 1);

   function automatic logic [PER_W-1:0] period_of(input int idx);
      return (CLK_FREQ_HZ == 50_000_000) ? NOTE_PERIOD[idx]
                                         : note_period(CLK_FREQ_HZ, NOTE_FREQ_HZ[idx]);
   endfunction

   fanfare_state_t   state_q, state_d;
   note_idx_t        note_q, note_d;
   logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;

   logic [PER_W-1:0] period;
   logic [DUR_W:0]   dur_lim, dur_sum;
   logic             note_end, playing, sq, tone_clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         note_q    <= '0;
         dur_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         note_q    <= note_d;
         dur_cnt_q <= dur_cnt_d;
      end
   end

   always_comb begin
      period  = period_of(NUM_NOTES - 1);
      dur_lim = NOTE_DUR[NUM_NOTES - 1];
      case (note_q)
         3'd0:    begin period = period_of(0); dur_lim = NOTE_DUR[0]; end
         3'd1:    begin period = period_of(1); dur_lim = NOTE_DUR[1]; end
         3'd2:    begin period = period_of(2); dur_lim = NOTE_DUR[2]; end
         3'd3:    begin period = period_of(3); dur_lim = NOTE_DUR[3]; end
         3'd4:    begin period = period_of(4); dur_lim = NOTE_DUR[4]; end
         default: ;
      endcase
   end

   // One extra bit so the sum cannot wrap at the 2^25 final-note length
   assign dur_sum  = {1'b0, dur_cnt_q} + (DUR_W+1)'(STEP_SIZE);
   assign note_end = (state_q == PLAY) && (dur_sum >= dur_lim);

   always_comb begin
      state_d   = state_q;
      note_d    = note_q;
      dur_cnt_d = dur_cnt_q;
      case (state_q)
         IDLE: if (go) begin
            state_d   = PLAY;
            note_d    = '0;
            dur_cnt_d = '0;
         end
         PLAY: if (note_end) begin
            dur_cnt_d = '0;
            if (note_q == LAST_NOTE) begin
               state_d = IDLE;
               note_d  = '0;
            end else begin
               note_d = note_q + 1'b1;
            end
         end else begin
            dur_cnt_d = dur_sum[DUR_W-1:0];
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      playing  = (state_q == PLAY);
      busy     = playing;
      done     = note_end && (note_q == LAST_NOTE);
      tone_clr = !playing || note_end;
      piezo    = playing && sq;
      piezo_n  = playing && !sq;
   end

   tone_gen u_tone (
      .clk    (clk),
      .rst    (rst),
      .period (period),
      .clr    (tone_clr),
      .sq     (sq)
   );

endmodule

// File: tb/tb_piezo_fanfare.sv
// Bench for piezo_fanfare, scaled (500 kHz clock, step 4096) so a full tune is 18432 clks.
module tb_piezo_fanfare;

   logic clk = 1'b0, rst = 1'b1, go = 1'b0;
   logic piezo, piezo_n, busy, done;

   always #5 clk = ~clk;

   piezo_fanfare #(.CLK_FREQ_HZ(500_000), .STEP_SIZE(4096)) dut (
      .clk(clk), .rst(rst), .go(go),
      .piezo(piezo), .piezo_n(piezo_n), .busy(busy), .done(done)
   );

   // Round(500000/f) and DUR/4096, worked out by hand
   localparam int PER [6] = '{319, 239, 190, 159, 190, 159};
   localparam int DUR [6] = '{2048, 2048, 2048, 3072, 1024, 8192};
   localparam int TOTAL   = 18432;

   int n_cmp = 0, n_bad = 0;

   // Model: is a tune playing, and how many clocks since it started
   bit m_play = 1'b0;
   int m_t    = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_play = 1'b0;
         m_t    = 0;
      end else if (!m_play) begin
         if (go) begin m_play = 1'b1; m_t = 0; end
      end else if (m_t == TOTAL - 1) begin
         m_play = 1'b0;
      end else begin
         m_t++;
      end
   end

   function automatic logic [3:0] model_out(input bit play, input int t);
      int o, k;
      bit sq;
      if (!play) return 4'b0000;
      o = t;
      k = 0;
      while (k < 5 && o >= DUR[k]) begin o -= DUR[k]; k++; end
      sq = (o % PER[k]) < (PER[k] / 2);
      return {sq, ~sq, 1'b1, (t == TOTAL - 1)};
   endfunction

   always @(negedge clk) begin
      logic [3:0] exp_v;
      exp_v = model_out(m_play, m_t);
      n_cmp++;
      if ({piezo, piezo_n, busy, done} !== exp_v) begin
         n_bad++;
         if (n_bad < 20)
            $display("FAIL cycle_model t=%0d play=%0b got {piezo,piezo_n,busy,done}=%b exp=%b",
                     m_t, m_play, {piezo, piezo_n, busy, done}, exp_v);
      end
   end

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp_v);
      n_cmp++;
      if (got !== exp_v) begin
         n_bad++;
         $display("FAIL %s got=%b exp=%b", name, got, exp_v);
      end
   endtask

   initial begin
      int done_t;
      bit found;

      // Reset, then sit idle with no go
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("idle_quiet", {piezo, piezo_n, busy, done}, 4'b0000);

      // Full tune with go repeated in note 3 and in the done cycle
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("busy_rise", {3'b000, busy}, 4'b0001);
      check("first_edge", {3'b000, piezo}, 4'b0001);
      found  = 1'b0;
      done_t = -1;
      for (int i = 0; i < TOTAL + 100 && !found; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 6500) go = 1'b1;
         if (i == 6501) go = 1'b0;
         if (done) begin
            done_t = i;
            found  = 1'b1;
            go     = 1'b1;
         end
      end
      @(negedge clk);
      go = 1'b0;
      check("done_time", {3'b000, found}, 4'b0001);
      if (done_t != TOTAL - 1) begin
         n_bad++;
         $display("FAIL done_offset got=%0d exp=%0d", done_t, TOTAL - 1);
      end
      n_cmp++;
      check("after_done", {piezo, piezo_n, busy, done}, 4'b0000);
      repeat (50) @(negedge clk);
      check("no_restart", {piezo, piezo_n, busy, done}, 4'b0000);

      // Second tune, reset asserted in note 4
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int i = 1; i <= 9500; i++) @(negedge clk);
      check("note4_busy", {3'b000, busy}, 4'b0001);
      #2 rst = 1'b1;
      #1 check("rst_async", {piezo, piezo_n, busy, done}, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Replay from note 0 with hand-computed tone edges
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int i = 0; i <= 2200; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 158)  check("n0_last_high", {3'b000, piezo}, 4'b0001);
         if (i == 159)  check("n0_first_low", {3'b000, piezo}, 4'b0000);
         if (i == 2047) check("n0_end",       {3'b000, piezo}, 4'b0001);
         if (i == 2048) check("n1_start",     {2'b00, piezo, piezo_n}, 4'b0010);
         if (i == 2166) check("n1_last_high", {3'b000, piezo}, 4'b0001);
         if (i == 2167) check("n1_first_low", {2'b00, piezo, piezo_n}, 4'b0001);
      end
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
